// File: rtl/serial_subtractor_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl_if
// Request/response bundle for the bit-serial subtractor.
//   start  request; only looked at while the subtractor is idle
//   a, b   minuend / subtrahend, captured with an accepted start
//   bin    initial borrow-in, captured with an accepted start
//   busy   subtractor is computing or presenting a result
//   done   one-cycle pulse, diff/bout valid
//   diff   a - b - bin modulo 2^WIDTH
//   bout   final borrow-out (1 when a < b + bin, unsigned)
// master: the requester side; slave: the subtractor side.
// ---------------------------------------------------------------------------
interface serial_subtractor_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   modport master (
      output start,
      output a,
      output b,
      output bin,
      input  busy,
      input  done,
      input  diff,
      input  bout
   );

   modport slave (
      input  start,
      input  a,
      input  b,
      input  bin,
      output busy,
      output done,
      output diff,
      output bout
   );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// serial_subtractor_ctrl
// Bit-serial WIDTH-bit subtractor: {bout,diff} = a - b - bin, computed LSB
// first through a single 1-bit full-subtractor cell, one bit per clock.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, overrides everything
//   bus   serial_subtractor_ctrl_if.slave (start/a/b/bin in,
//         busy/done/diff/bout out)
// Timing: a start accepted at edge E runs the cell on edges E+1..E+WIDTH;
// done is high in the cycle after edge E+WIDTH. Starts seen while busy are
// dropped. All outputs come straight from registers.
// ---------------------------------------------------------------------------

// One-bit full subtractor: {bout,d} = a - b - bin.
module full_subtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   // Borrow when b+bin exceeds a: either a=0 with b=1, or a==b with a
   // pending borrow.
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   serial_subtractor_ctrl_if.slave   bus
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_reg,   state_next;
   logic [CNT_W-1:0] cnt_reg,     cnt_next;
   logic [WIDTH-1:0] sa_reg,      sa_next;
   logic [WIDTH-1:0] sb_reg,      sb_next;
   logic             borrow_reg,  borrow_next;
   // Holds the WIDTH-1 result bits produced so far; the last bit comes
   // straight from the cell on the final edge, so one bit less is enough.
   logic [WIDTH-2:0] diff_sr_reg, diff_sr_next;
   logic [WIDTH-1:0] diff_reg,    diff_next;
   logic             bout_reg,    bout_next;

   logic             cell_d;
   logic             cell_bout;
   logic [WIDTH-1:0] shift_full;

   full_subtractor_cell u_cell (
      .a    (sa_reg[0]),
      .b    (sb_reg[0]),
      .bin  (borrow_reg),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // New bit enters at the MSB; after WIDTH shifts bit 0 is the LSB result.
   assign shift_full = {cell_d, diff_sr_reg};

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      sa_next      = sa_reg;
      sb_next      = sb_reg;
      borrow_next  = borrow_reg;
      diff_sr_next = diff_sr_reg;
      diff_next    = diff_reg;
      bout_next    = bout_reg;

      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               sa_next      = bus.a;
               sb_next      = bus.b;
               borrow_next  = bus.bin;
               cnt_next     = '0;
               diff_sr_next = '0;
               state_next   = RUN;
            end
         end

         RUN: begin
            sa_next      = sa_reg >> 1;
            sb_next      = sb_reg >> 1;
            borrow_next  = cell_bout;
            diff_sr_next = shift_full[WIDTH-1:1];
            cnt_next     = cnt_reg + CNT_W'(1);
            if (cnt_reg == LAST_BIT) begin
               // Publish only the complete word so partial shifts never
               // reach diff.
               diff_next  = shift_full;
               bout_next  = cell_bout;
               cnt_next   = '0;
               state_next = DONE;
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         sa_reg      <= '0;
         sb_reg      <= '0;
         borrow_reg  <= 1'b0;
         diff_sr_reg <= '0;
         diff_reg    <= '0;
         bout_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         sa_reg      <= sa_next;
         sb_reg      <= sb_next;
         borrow_reg  <= borrow_next;
         diff_sr_reg <= diff_sr_next;
         diff_reg    <= diff_next;
         bout_reg    <= bout_next;
      end
   end

   assign bus.busy = (state_reg == RUN) || (state_reg == DONE);
   assign bus.done = (state_reg == DONE);
   assign bus.diff = diff_reg;
   assign bus.bout = bout_reg;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_ctrl
// Drives an 8-bit and a 4-bit subtractor. Stimulus pushes expected
// {bout,diff} words into per-instance queues; monitors pop and compare on
// every done pulse, and flag any done that nothing was queued for.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst8;
   logic rst4;

   serial_subtractor_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_subtractor_ctrl_if #(.WIDTH(4)) bus4 ();

   serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
      .clk (clk),
      .rst (rst8),
      .bus (bus8.slave)
   );

   serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
      .clk (clk),
      .rst (rst4),
      .bus (bus4.slave)
   );

   int checks = 0;
   int errors = 0;
   int issued8 = 0;
   int issued4 = 0;
   int done8_seen = 0;
   int done4_seen = 0;

   logic [8:0] exp8_q[$];
   logic [4:0] exp4_q[$];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitors ----------------
   always @(negedge clk) begin : mon8
      logic [8:0] e;
      if (bus8.done === 1'b1) begin
         done8_seen++;
         if (exp8_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w8_unexpected_done actual diff=%0d bout=%0d required no done",
                     bus8.diff, bus8.bout);
         end else begin
            e = exp8_q.pop_front();
            $display("w8 txn: diff=%0d bout=%0d expect diff=%0d bout=%0d",
                     bus8.diff, bus8.bout, e[7:0], e[8]);
            check("w8_result", {23'd0, bus8.bout, bus8.diff}, {23'd0, e});
         end
      end
   end

   always @(negedge clk) begin : mon4
      logic [4:0] e;
      if (bus4.done === 1'b1) begin
         done4_seen++;
         if (exp4_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL w4_unexpected_done actual diff=%0d bout=%0d required no done",
                     bus4.diff, bus4.bout);
         end else begin
            e = exp4_q.pop_front();
            $display("w4 txn: diff=%0d bout=%0d expect diff=%0d bout=%0d",
                     bus4.diff, bus4.bout, e[3:0], e[4]);
            check("w4_result", {27'd0, bus4.bout, bus4.diff}, {27'd0, e});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   // Called one step after an edge with the DUT idle; returns one step after
   // the accepting edge with start already dropped.
   task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                         input logic bin, input logic push,
                         input logic [7:0] ed, input logic ebo);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.bin   = bin;
      if (push) begin
         exp8_q.push_back({ebo, ed});
         issued8++;
      end
      tick();
      bus8.start = 1'b0;
      check("w8_accept_busy", {31'd0, bus8.busy}, 32'd1);
   endtask

   task automatic wait_idle8();
      int n = 0;
      while (bus8.busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         checks++;
         errors++;
         $display("FAIL w8_idle_timeout actual busy=%0d required busy=0", bus8.busy);
      end
   endtask

   task automatic wait_idle4();
      int n = 0;
      while (bus4.busy === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL w4_idle_timeout actual busy=%0d required busy=0", bus4.busy);
      end
   endtask

   // Directed 8-bit vectors: a, b, bin, expected diff, expected bout.
   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec8_t;

   vec8_t vecs[5] = '{
      '{8'd100, 8'd37,  1'b0, 8'd63,  1'b0},
      '{8'd5,   8'd10,  1'b0, 8'd251, 1'b1},
      '{8'd0,   8'd0,   1'b1, 8'hFF,  1'b1},
      '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1},
      '{8'hFF,  8'h00,  1'b0, 8'hFF,  1'b0}
   };

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : stim
      int lat;
      int busy_cnt;
      int k;
      int n;

      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
      rst8 = 1'b1;
      rst4 = 1'b1;
      repeat (3) tick();
      rst8 = 1'b0;
      rst4 = 1'b0;

      check("w8_reset_busy", {31'd0, bus8.busy}, 32'd0);
      check("w8_reset_done", {31'd0, bus8.done}, 32'd0);
      check("w8_reset_diff", {24'd0, bus8.diff}, 32'd0);
      check("w8_reset_bout", {31'd0, bus8.bout}, 32'd0);
      check("w4_reset_busy", {31'd0, bus4.busy}, 32'd0);
      check("w4_reset_diff", {28'd0, bus4.diff}, 32'd0);
      check("w4_reset_bout", {31'd0, bus4.bout}, 32'd0);

      // Test 1: latency and busy length on the first vector.
      issue8(vecs[0].a, vecs[0].b, vecs[0].bin, 1'b1, vecs[0].d, vecs[0].bo);
      lat = 0;
      busy_cnt = 0;
      k = 1;
      while (k <= 20) begin
         if (bus8.busy === 1'b1) busy_cnt++;
         if (bus8.done === 1'b1 && lat == 0) lat = k;
         if (bus8.busy !== 1'b1) break;
         tick();
         k++;
      end
      check("w8_latency", lat, 32'd9);
      check("w8_busy_cycles", busy_cnt, 32'd9);
      wait_idle8();

      // Remaining directed vectors, back to back.
      for (int i = 1; i < 5; i++) begin
         issue8(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1, vecs[i].d, vecs[i].bo);
         wait_idle8();
      end

      // Test 4: starts during RUN and DONE are dropped; IDLE start accepted.
      issue8(8'd10, 8'd3, 1'b0, 1'b1, 8'd7, 1'b0);
      tick();
      tick();
      bus8.start = 1'b1; bus8.a = 8'd200; bus8.b = 8'd1; bus8.bin = 1'b0;
      tick();
      bus8.start = 1'b0;
      n = 0;
      while (bus8.done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("w8_reach_done", {31'd0, bus8.done}, 32'd1);
      bus8.start = 1'b1; bus8.a = 8'd50; bus8.b = 8'd60; bus8.bin = 1'b0;
      tick();
      check("w8_idle_after_done", {31'd0, bus8.busy}, 32'd0);
      issue8(8'd9, 8'd4, 1'b1, 1'b1, 8'd4, 1'b0);
      wait_idle8();

      // Test 5: reset at cnt=4 aborts, clears outputs, no done follows.
      issue8(8'd77, 8'd11, 1'b0, 1'b0, 8'd0, 1'b0);
      repeat (4) tick();
      rst8 = 1'b1;
      tick();
      rst8 = 1'b0;
      check("w8_abort_busy", {31'd0, bus8.busy}, 32'd0);
      check("w8_abort_done", {31'd0, bus8.done}, 32'd0);
      check("w8_abort_diff", {24'd0, bus8.diff}, 32'd0);
      check("w8_abort_bout", {31'd0, bus8.bout}, 32'd0);
      repeat (12) tick();
      issue8(8'd77, 8'd11, 1'b0, 1'b1, 8'd66, 1'b0);
      wait_idle8();

      // Test 6: exhaustive 4-bit sweep, back-to-back starts.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               logic [4:0] r;
               r = 5'(a) - 5'(b) - 5'(c);
               bus4.start = 1'b1;
               bus4.a     = 4'(a);
               bus4.b     = 4'(b);
               bus4.bin   = c[0];
               exp4_q.push_back(r);
               issued4++;
               tick();
               bus4.start = 1'b0;
               wait_idle4();
            end
         end
      end

      repeat (4) tick();
      check("w8_pending", exp8_q.size(), 32'd0);
      check("w4_pending", exp4_q.size(), 32'd0);
      check("w8_done_count", done8_seen, issued8);
      check("w4_done_count", done4_seen, issued4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
